kvaz_multi: RTL

KVAZ_MULTI -- requirements
Module: kvaz_multi

---
 rtl/kvaz_multi.sv | 108 ++++++++++
 1 files changed

// File: rtl/kvaz_multi.sv
// Multi-disk RAM window controller: per-disk control registers with deferred writes.
// Define KVAZ_WIDE_WINDOW_EN to let cr[6] widen the window to 8000-FFFF.
module kvaz_multi #(
   parameter int NUM_DISKS = 2,
   parameter int PAGE_W    = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clke,
   input  logic [15:0]          address,
   input  logic [NUM_DISKS-1:0] sel,
   input  logic [7:0]           data_in,
   input  logic                 stack,
   input  logic                 memwr,
   input  logic                 memrd,
   output logic [PAGE_W-1:0]    bigram_addr,
   output logic                 pending,
   input  logic [1:0]           debug_sel,
   output logic [7:0]           debug
);

   logic [7:0]           cr        [NUM_DISKS];
   logic [7:0]           pend_data [NUM_DISKS];
   logic [NUM_DISKS-1:0] pend;
   logic                 access;
   logic [NUM_DISKS-1:0] hit_s;
   logic [NUM_DISKS-1:0] hit_w;
   logic [PAGE_W-1:0]    next_page;

   assign access = memwr | memrd;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int d = 0; d < NUM_DISKS; d++) begin
            cr[d]        <= 8'h00;
            pend_data[d] <= 8'h00;
            pend[d]      <= 1'b0;
         end
      end else begin
         for (int d = 0; d < NUM_DISKS; d++) begin
            if (clke && sel[d] && !access) begin
               cr[d]   <= data_in;
               pend[d] <= 1'b0;
            end else if (clke && sel[d]) begin
               pend_data[d] <= data_in;
               pend[d]      <= 1'b1;
            end else if (clke && !access && pend[d]) begin
               cr[d]   <= pend_data[d];
               pend[d] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      logic win;
      hit_s = '0;
      hit_w = '0;
      for (int d = 0; d < NUM_DISKS; d++) begin
         win = (address[15:12] >= 4'hA) && (address[15:12] <= 4'hD);
`ifdef KVAZ_WIDE_WINDOW_EN
         if (cr[d][6])
            win = address[15];
`endif
         hit_s[d] = cr[d][4] & stack & access;
         hit_w[d] = cr[d][5] & win & access;
      end
   end

   // Window hits are resolved first so a stack hit can override them.
   always_comb begin
      logic fw;
      logic fs;
      next_page = '0;
      fw = 1'b0;
      fs = 1'b0;
      for (int d = 0; d < NUM_DISKS; d++) begin
         if (!fw && hit_w[d]) begin
            next_page = PAGE_W'(1 + 4 * d) + PAGE_W'(cr[d][1:0]);
            fw = 1'b1;
         end
      end
      for (int d = 0; d < NUM_DISKS; d++) begin
         if (!fs && hit_s[d]) begin
            next_page = PAGE_W'(1 + 4 * d) + PAGE_W'(cr[d][3:2]);
            fs = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         bigram_addr <= '0;
      else
         bigram_addr <= next_page;
   end

   assign pending = |pend;

   always_comb begin
      debug = 8'h00;
      for (int d = 0; d < NUM_DISKS; d++) begin
         if (debug_sel == 2'(d))
            debug = cr[d];
      end
   end

endmodule
